// File: rtl/nn_layer_pkg.sv
// Shared definitions for the dense-layer inference pipeline: data width default,
// classifier FSM state type and the index-width helper.
package nn_layer_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    COLLECT,
    EMIT_IDX,
    EMIT_VAL
  } state_t;

  // Width of an index into a frame of m values (m >= 2).
  function automatic int idx_width(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/argmax_tracker.sv
// Running-maximum tracker: holds the best value/index of the current frame.
// Optional ARGMAX_VALUE_OUT_EN exposes the registered maximum value.
module argmax_tracker
  import nn_layer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int IDXW  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic                    first,
  input  logic signed [WIDTH-1:0] value,
  input  logic        [IDXW-1:0]  index,
`ifdef ARGMAX_VALUE_OUT_EN
  output logic signed [WIDTH-1:0] max_val_q,
`endif
  output logic        [IDXW-1:0]  nxt_idx
);

  logic signed [WIDTH-1:0] max_val;
  logic signed [WIDTH-1:0] nxt_val;
  logic        [IDXW-1:0]  max_idx;
  logic                    take;

  // Strict signed compare: ties keep the earlier (lower) index.
  assign take    = load && (first || (value > max_val));
  assign nxt_val = take ? value : max_val;
  assign nxt_idx = take ? index : max_idx;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_val <= '0;
      max_idx <= '0;
    end else begin
      max_val <= nxt_val;
      max_idx <= nxt_idx;
    end
  end

`ifdef ARGMAX_VALUE_OUT_EN
  assign max_val_q = max_val;
`endif

endmodule

// File: rtl/layer_argmax_16.sv
// Argmax classifier stage: collects M streamed layer outputs and emits the winning
// class index (and, with ARGMAX_VALUE_OUT_EN defined, the maximum value as a second beat).
module layer_argmax_16
  import nn_layer_pkg::*;
#(
  parameter int M     = 16,
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int IDXW  = idx_width(M)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [WIDTH-1:0] data_in,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [WIDTH-1:0] data_out
);

  state_t          state, state_nxt;
  logic [IDXW:0]   cnt;
  logic            accept;
  logic            last;
  logic [IDXW-1:0] nxt_idx;
`ifdef ARGMAX_VALUE_OUT_EN
  logic signed [WIDTH-1:0] max_val;
`endif

  // s_ready is only ever high in COLLECT, so accept implies COLLECT.
  assign accept = s_valid && s_ready;
  assign last   = (cnt == (IDXW+1)'(M-1));

  argmax_tracker #(
    .WIDTH (WIDTH),
    .IDXW  (IDXW)
  ) u_tracker (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .first     (cnt == '0),
    .value     (data_in),
    .index     (cnt[IDXW-1:0]),
`ifdef ARGMAX_VALUE_OUT_EN
    .max_val_q (max_val),
`endif
    .nxt_idx   (nxt_idx)
  );

  // NOTE: next-state is assigned a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT:  if (accept && last) state_nxt = EMIT_IDX;
`ifdef ARGMAX_VALUE_OUT_EN
      EMIT_IDX: if (m_ready) state_nxt = EMIT_VAL;
      EMIT_VAL: if (m_ready) state_nxt = COLLECT;
`else
      EMIT_IDX: if (m_ready) state_nxt = COLLECT;
`endif
      default:  state_nxt = COLLECT;
    endcase
  end

  // Handshake flags are registered from the next state, so s_ready stays low
  // until the first edge after reset releases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= COLLECT;
      s_ready  <= 1'b0;
      m_valid  <= 1'b0;
      cnt      <= '0;
      data_out <= '0;
    end else begin
      state   <= state_nxt;
      s_ready <= (state_nxt == COLLECT);
      m_valid <= (state_nxt != COLLECT);
      if (accept) cnt <= last ? '0 : cnt + (IDXW+1)'(1);
      // Index comes from the tracker's next value so it includes the last beat.
      if (accept && last) data_out <= WIDTH'(nxt_idx);
`ifdef ARGMAX_VALUE_OUT_EN
      else if (state == EMIT_IDX && m_ready) data_out <= max_val;
`endif
    end
  end

endmodule

// File: tb/tb_layer_argmax_16.sv
// Self-checking bench for layer_argmax_16: directed and random frames against an
// array-based argmax reference; follows ARGMAX_VALUE_OUT_EN for the value beat.
module tb_layer_argmax_16;

  localparam int N = 16;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic signed [15:0] data_in = '0;
  logic               m_valid;
  logic               m_ready = 1'b0;
  logic signed [15:0] data_out;

  logic signed [15:0] frame [N];
  int vectors = 0;
  int miscompares = 0;

  layer_argmax_16 dut (
    .clk      (clk),
    .reset    (reset),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .data_in  (data_in),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: first position holding the largest signed value.
  function automatic int ref_idx();
    int best = 0;
    for (int i = 1; i < N; i++) if (frame[i] > frame[best]) best = i;
    return best;
  endfunction

  function automatic int ref_val();
    return int'(frame[ref_idx()]);
  endfunction

  // Called at a negedge; returns at the negedge after the last accepted beat.
  task automatic send_frame(input int n);
    for (int i = 0; i < n; i++) begin
      int budget = 0;
      data_in = frame[i];
      s_valid = 1'b1;
      while (!s_ready && budget < 50) begin
        @(negedge clk);
        budget++;
      end
      if (budget >= 50) check("s_ready_timeout", 0, 1);
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  task automatic recv_beat(input string tag, input int exp);
    int budget = 0;
    m_ready = 1'b1;
    while (!m_valid && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 50) check({tag, "_timeout"}, 0, 1);
    check(tag, data_out, exp);
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  task automatic expect_result(input string tag);
    int ei = ref_idx();
    int ev = ref_val();
    check({tag, "_latency"}, m_valid, 1);
    recv_beat({tag, "_idx"}, ei);
`ifdef ARGMAX_VALUE_OUT_EN
    check({tag, "_val_follows"}, m_valid, 1);
    recv_beat({tag, "_val"}, ev);
`else
    if (ev != ev + 1) check({tag, "_single_beat"}, m_valid, 0);
`endif
    check({tag, "_ready_after"}, s_ready, 1);
  endtask

  initial begin
    logic signed [15:0] q [$];
    int beats [$];
    int exp_beats [$];
    int ptr, gap, budget;
    logic sr, mv;
    logic signed [15:0] dv;

    // Reset values and s_ready rising on the first edge after release.
    #3;
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_data_out", data_out, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("s_ready_before_edge", s_ready, 0);
    @(negedge clk);
    check("s_ready_after_edge", s_ready, 1);

    // Tie: 9 at positions 1 and 3 keeps 1.
    foreach (frame[i]) frame[i] = 16'sd0;
    frame[0] = 16'sd5; frame[1] = 16'sd9; frame[2] = 16'sd3; frame[3] = 16'sd9;
    send_frame(N);
    expect_result("tie");

    // All-zero frame.
    foreach (frame[i]) frame[i] = 16'sd0;
    send_frame(N);
    expect_result("zeros");

    // Monotonic 1..16 with the consumer stalled for 5 cycles.
    foreach (frame[i]) frame[i] = 16'(i + 1);
    send_frame(N);
    for (int c = 0; c < 5; c++) begin
      check("stall_m_valid", m_valid, 1);
      check("stall_data", data_out, 15);
      check("stall_s_ready", s_ready, 0);
      @(negedge clk);
    end
    expect_result("mono");

    // Back-to-back frames, s_valid and m_ready held high.
    for (int i = 0; i < N; i++) q.push_back(16'(i + 1));
    for (int i = 0; i < N; i++) q.push_back(16'(N - i));
    exp_beats.push_back(15);
`ifdef ARGMAX_VALUE_OUT_EN
    exp_beats.push_back(16);
`endif
    exp_beats.push_back(0);
`ifdef ARGMAX_VALUE_OUT_EN
    exp_beats.push_back(16);
`endif
    ptr = 0; gap = 0; budget = 0;
    m_ready = 1'b1;
    while (!(ptr == 2 * N && beats.size() == exp_beats.size()) && budget < 200) begin
      sr = s_ready; mv = m_valid; dv = data_out;
      s_valid = (ptr < 2 * N);
      data_in = (ptr < 2 * N) ? q[ptr] : 16'sd0;
      if (mv) beats.push_back(int'(dv));
      if (!sr && ptr == N) gap++;
      if (sr && s_valid) ptr++;
      @(negedge clk);
      budget++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    m_ready = 1'b0;
    check("b2b_beats_taken", ptr, 2 * N);
    check("b2b_beat_count", beats.size(), exp_beats.size());
    for (int i = 0; i < exp_beats.size() && i < beats.size(); i++)
      check($sformatf("b2b_beat%0d", i), beats[i], exp_beats[i]);
`ifdef ARGMAX_VALUE_OUT_EN
    check("b2b_gap", gap, 2);
`else
    check("b2b_gap", gap, 1);
`endif
    check("b2b_idle", s_ready, 1);

    // Partial frame discarded by a mid-frame reset.
    foreach (frame[i]) frame[i] = 16'sd200;
    send_frame(7);
    #2 reset = 1'b1;
    #1;
    check("midrst_s_ready", s_ready, 0);
    check("midrst_m_valid", m_valid, 0);
    check("midrst_data_out", data_out, 0);
    @(negedge clk);
    reset = 1'b0;
    foreach (frame[i]) frame[i] = 16'($urandom_range(0, 99));
    frame[12] = 16'sd100;
    send_frame(N);
    check("postrst_ref", ref_idx(), 12);
    expect_result("postrst");
    repeat (3) @(negedge clk);
    check("postrst_no_stale", m_valid, 0);

    // Negative inputs exercise the signed compare.
    frame[0] = -16'sd5; frame[1] = -16'sd3; frame[2] = -16'sd9;
    for (int i = 3; i < N; i++) frame[i] = -16'($urandom_range(4, 1000));
    send_frame(N);
    expect_result("negative");

    // Random frames: full signed range, then a narrow range for frequent ties.
    for (int f = 0; f < 8; f++) begin
      foreach (frame[i])
        frame[i] = (f < 4) ? 16'($urandom) : 16'($urandom_range(0, 3)) - 16'sd1;
      send_frame(N);
      expect_result($sformatf("rand%0d", f));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
